mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning data word width in bits; only the value 32 is supported.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 4, meaning word-address width of the attached byte-addressable memory.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  block can accept a request.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 Port req_unsigned  input  1  for loads, 1 = zero-extend and 0 = sign-extend.
REQ-010 Port req_addr  input  ADDRESS_WIDTH+2  byte address.
REQ-011 Port req_wdata  input  32  store data, right-aligned.
REQ-012 Port resp_valid  output  1  one-cycle completion pulse.
REQ-013 Port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 Port resp_err  output  1  illegal size flag, valid with resp_valid.
REQ-015 Port mem_addr  output  ADDRESS_WIDTH  memory word address.
REQ-016 Port mem_byte_en  output  4  per-byte write enable; bit i enables byte lane [8i+7:8i].
REQ-017 Port mem_din  output  32  memory write data.
REQ-018 Port mem_dout  input  32  memory read data; registered write-first, so it returns the word at the mem_addr driven in the previous cycle, including that cycle's write.

Function
REQ-019 Offset o = req_addr[1:0]; word address w = req_addr[ADDRESS_WIDTH+1:2].
REQ-020 An access SHALL be split into two memory accesses when it is a half with o = 3, or a word with o != 0.
REQ-021 FSM states SHALL be IDLE, ACC_LO, ACC_HI, CAP and RESP.
- IDLE: req_ready = 1; on req_valid the block latches all req_* and goes to ACC_LO.
- ACC_LO: mem_addr = w; goes to ACC_HI if split, else to CAP.
- ACC_HI: mem_addr = w+1, wrapping modulo 2^ADDRESS_WIDTH; latches mem_dout into lo_buf; goes to CAP.
- CAP: latches mem_dout into hi_buf if split, else into lo_buf; registers resp_rdata and resp_err; goes to RESP.
- RESP: resp_valid = 1; goes to IDLE.
REQ-022 req_ready SHALL be 0 in every state except IDLE; requests not accepted are ignored.
REQ-023 Latency from the accept edge to the resp_valid cycle SHALL be 3 cycles for aligned accesses and 4 cycles for split accesses.
REQ-024 Store byte enables (mem_byte_en) SHALL be:
- byte: 1<<o in ACC_LO.
- half, o <= 2: 0011<<o in ACC_LO.
- half, o = 3: 1000 in ACC_LO and 0001 in ACC_HI.
- word: (1111<<o)[3:0] in ACC_LO and 1111>>(4-o) in ACC_HI.
REQ-025 Store data (mem_din) SHALL be (wdata<<8o)[31:0] in ACC_LO and wdata>>(8(4-o)) in ACC_HI.
REQ-026 mem_byte_en SHALL be 0000 in IDLE, CAP and RESP, and for all loads and illegal sizes.
REQ-027 mem_din SHALL be 0 whenever mem_byte_en = 0000.
REQ-028 Load data SHALL be assembled as the 64-bit value {hi_buf, lo_buf} shifted right by 8o.
- The low 8, 16 or 32 bits are kept according to req_size.
- The result is extended per req_unsigned; hi_buf is treated as 0 when the access is not split.
REQ-029 Illegal size (req_size = 11) SHALL follow the aligned timing with no write, giving resp_err = 1 and resp_rdata = 0.
REQ-030 Store responses SHALL give resp_rdata = 0 and resp_err = 0.
REQ-031 The response SHALL be a pulse with no backpressure; resp_rdata and resp_err hold their values until the next CAP.

Reset
REQ-032 While rst = 1 at a rising edge, the block SHALL enter IDLE and clear lo_buf, hi_buf, resp_rdata and resp_err.
REQ-033 During the cycle after that edge, resp_valid, mem_byte_en, mem_din and mem_addr SHALL be 0.
REQ-034 req_ready SHALL be 0 while rst = 1 and 1 in the first cycle after rst deasserts.
REQ-035 Reset mid-operation SHALL abort the access with no resp_valid.
- A split store already past ACC_LO keeps its low-part write; no rollback.

Verification
REQ-036 Aligned word: sw addr 0x04, wdata 0xDEADBEEF -> ACC_LO with mem_addr 1, be 1111, din 0xDEADBEEF; then lw 0x04 -> resp_rdata 0xDEADBEEF, resp_valid 3 cycles after accept.
REQ-037 Byte and extension: sb 0x07, wdata 0xA5 -> be 1000, din 0xA5000000; then lb 0x07 -> 0xFFFFFFA5; lbu 0x07 -> 0x000000A5.
REQ-038 Split word: sw 0x05, wdata 0x11223344 -> ACC_LO addr 1, be 1110, din 0x22334400; ACC_HI addr 2, be 0001, din 0x00000011; then lw 0x05 -> 0x11223344 with 4-cycle latency.
REQ-039 Address wrap: sh 0x3F, wdata 0x8001 -> lo access addr 15, be 1000; hi access addr 0, be 0001; then lh 0x3F -> 0xFFFF8001.
REQ-040 Illegal size: req_size 11 -> mem_byte_en 0000 throughout, resp_err 1, resp_rdata 0, resp_valid 3 cycles after accept.
REQ-041 Reset in ACC_HI of a split store -> next cycle IDLE with mem_byte_en 0000 and no resp_valid; req_ready 1 after rst deasserts; the low bytes remain written.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit for a word-wide, byte-addressable synchronous memory.
// Handles sub-word and misaligned accesses, splitting across two words when needed.
module mem_access_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [3:0]               mem_byte_en,
  output logic [DATA_WIDTH-1:0]    mem_din,
  input  logic [DATA_WIDTH-1:0]    mem_dout
);

  typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, CAP, RESP} state_t;

  state_t                   state_q, state_d;
  logic                     we_q, uns_q;
  logic [1:0]               size_q;
  logic [ADDRESS_WIDTH+1:0] addr_q;
  logic [31:0]              wdata_q;
  logic [31:0]              lo_buf_q, hi_buf_q, rdata_q;
  logic                     err_q;

  logic [1:0]               off;
  logic [ADDRESS_WIDTH-1:0] word;
  logic                     split, illegal, store_ok;
  logic [3:0]               base_mask;
  logic [7:0]               mask8;
  logic [63:0]              wdata64;
  logic [31:0]              lo_v, hi_v, assembled, load_res;

  function automatic logic [31:0] ext_load(input logic [31:0] v, input logic [1:0] sz,
                                           input logic uns);
    logic [31:0] r;
    case (sz)
      2'b00:   r = uns ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   r = uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign off      = addr_q[1:0];
  assign word     = addr_q[ADDRESS_WIDTH+1:2];
  assign split    = ((size_q == 2'b01) && (off == 2'd3)) || ((size_q == 2'b10) && (off != 2'd0));
  assign illegal  = (size_q == 2'b11);
  assign store_ok = we_q && !illegal;

  always_comb begin
    case (size_q)
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      2'b10:   base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
  end

  // Shifting into a 64-bit window yields the low-word and high-word parts at once.
  assign mask8     = {4'b0000, base_mask} << off;
  assign wdata64   = {32'b0, wdata_q} << {off, 3'b000};
  assign lo_v      = split ? lo_buf_q : mem_dout;
  assign hi_v      = split ? mem_dout : 32'b0;
  assign assembled = 32'({hi_v, lo_v} >> {off, 3'b000});
  assign load_res  = ext_load(assembled, size_q, uns_q);

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_addr    = '0;
    mem_byte_en = 4'b0000;
    mem_din     = '0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) state_d = ACC_LO;
      end
      ACC_LO: begin
        mem_addr = word;
        if (store_ok) begin
          mem_byte_en = mask8[3:0];
          mem_din     = (mask8[3:0] != 4'b0000) ? wdata64[31:0] : 32'b0;
        end
        state_d = split ? ACC_HI : CAP;
      end
      ACC_HI: begin
        mem_addr = word + 1'b1;
        if (store_ok) begin
          mem_byte_en = mask8[7:4];
          mem_din     = (mask8[7:4] != 4'b0000) ? wdata64[63:32] : 32'b0;
        end
        state_d = CAP;
      end
      CAP:  state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_buf_q <= '0;
      hi_buf_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ACC_HI) lo_buf_q <= mem_dout;
      if (state_q == CAP) begin
        if (split) hi_buf_q <= mem_dout;
        else       lo_buf_q <= mem_dout;
        rdata_q <= (we_q || illegal) ? 32'b0 : load_res;
        err_q   <= illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
